board_io_ctrl: RTL and testbench



---
 rtl/board_io_pkg.sv | 23 ++
 rtl/sw_debounce.sv | 62 ++++++
 rtl/board_io_ctrl.sv | 135 +++++++++++++
 tb/tb_board_io_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/board_io_pkg.sv
// board_io_pkg
//   Shared definitions for the board I/O conditioning block:
//   - led_mode encodings (LED_PASS, LED_PWM, LED_HB, LED_WALK)
//   - default debounce and reset-stretch lengths used by board_io_ctrl
//   - cnt_width(): counter width for a modulo-n counter, never below 1 bit
package board_io_pkg;

  typedef enum logic [1:0] {
    LED_PASS = 2'd0,
    LED_PWM  = 2'd1,
    LED_HB   = 2'd2,
    LED_WALK = 2'd3
  } led_mode_e;

  localparam int DEF_DEBOUNCE_CYC = 1000;
  localparam int DEF_RST_STRETCH  = 16;

  // Width needed to count 0..n-1; a degenerate n=1 counter still gets one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// sw_debounce
//   Conditions one slide switch: 2-flop synchroniser, stable-count debounce
//   and a rising-edge pulse on the debounced level.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   sw_raw   in   asynchronous switch pin
//   sw_db    out  debounced level; changes only after DEBOUNCE_CYC
//                 consecutive cycles of disagreement with the synced input
//   sw_rise  out  high for the first cycle in which sw_db reads 1 after 0
module sw_debounce
  import board_io_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw,
  output logic sw_db,
  output logic sw_rise
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // Stage p0/p1: metastability synchroniser, p1 is the usable value
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= sw_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: any cycle of agreement restarts the count, so a glitch can
  // never accumulate towards a level change.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      sw_db   <= 1'b0;
      sw_rise <= 1'b0;
    end else begin
      sw_rise <= 1'b0;
      if (sync_p1 == sw_db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt     <= '0;
        sw_db   <= sync_p1;
        sw_rise <= sync_p1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_io_ctrl.sv
// board_io_ctrl
//   Board-level I/O conditioning between FPGA pins and the CPU core.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high block reset
//   sw_raw     in   [NUM_SW]   asynchronous switch pins
//   sw_db      out  [NUM_SW]   debounced switch levels
//   sw_rise    out  [NUM_SW]   one-cycle pulse on each debounced 0->1
//   cpu_reset  out             CPU reset: high while reset or sw_db[0] is
//                              high, then for RST_STRETCH further cycles
//   led_in     in   [NUM_LED]  LED bus from the CPU
//   led_mode   in   [2]        0 pass, 1 pwm, 2 heartbeat, 3 walking one
//   pwm_duty   in   [PWM_BITS] lit cycles per 2^PWM_BITS in pwm mode
//   led_out    out  [NUM_LED]  registered LED pins
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int NUM_SW       = 4,
  parameter int NUM_LED      = 8,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int RST_STRETCH  = DEF_RST_STRETCH,
  parameter int PWM_BITS     = 4,
  parameter int HB_CYC       = 500,
  parameter int WALK_CYC     = 250
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_SW-1:0]   sw_raw,
  output logic [NUM_SW-1:0]   sw_db,
  output logic [NUM_SW-1:0]   sw_rise,
  output logic                cpu_reset,
  input  logic [NUM_LED-1:0]  led_in,
  input  logic [1:0]          led_mode,
  input  logic [PWM_BITS-1:0] pwm_duty,
  output logic [NUM_LED-1:0]  led_out
);

  localparam int               RST_W     = cnt_width(RST_STRETCH + 1);
  localparam logic [RST_W-1:0] RST_LOAD  = RST_W'(RST_STRETCH);
  localparam int               HB_W      = cnt_width(HB_CYC);
  localparam logic [HB_W-1:0]  HB_LAST   = HB_W'(HB_CYC - 1);
  localparam int               WALK_W    = cnt_width(WALK_CYC);
  localparam logic [WALK_W-1:0] WALK_LAST = WALK_W'(WALK_CYC - 1);

  // Switch conditioning, one independent channel per switch
  for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
    sw_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_sw_debounce (
      .clk    (clk),
      .reset  (reset),
      .sw_raw (sw_raw[g]),
      .sw_db  (sw_db[g]),
      .sw_rise(sw_rise[g])
    );
  end

  // Reset stretcher. The counter holds RST_STRETCH while the cause is
  // present and drains once it clears; the output is combined with the
  // cause combinationally so cpu_reset rises in the same cycle as sw_db[0].
  logic             rst_cause;
  logic [RST_W-1:0] rst_cnt;

  assign rst_cause = reset | sw_db[0];

  always_ff @(posedge clk) begin
    if (rst_cause) begin
      rst_cnt <= RST_LOAD;
    end else if (rst_cnt != '0) begin
      rst_cnt <= rst_cnt - 1'b1;
    end
  end

  assign cpu_reset = rst_cause | (rst_cnt != '0);

  // Free-running PWM and heartbeat timebases, independent of led_mode
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [HB_W-1:0]     hb_cnt;
  logic                hb;
  logic                pwm_lit;

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
      hb_cnt  <= '0;
      hb      <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (hb_cnt == HB_LAST) begin
        hb_cnt <= '0;
        hb     <= ~hb;
      end else begin
        hb_cnt <= hb_cnt + 1'b1;
      end
    end
  end

  assign pwm_lit = (pwm_cnt < pwm_duty);

  // Walking-one pointer; parked on bit 0 whenever walk mode is not selected
  // so every entry into walk mode starts from the first LED.
  led_mode_e          mode;
  logic [NUM_LED-1:0] walk_ptr;
  logic [WALK_W-1:0]  walk_cnt;

  assign mode = led_mode_e'(led_mode);

  always_ff @(posedge clk) begin
    if (reset || (mode != LED_WALK)) begin
      walk_ptr <= NUM_LED'(1);
      walk_cnt <= '0;
    end else if (walk_cnt == WALK_LAST) begin
      walk_cnt <= '0;
      walk_ptr <= {walk_ptr[NUM_LED-2:0], walk_ptr[NUM_LED-1]};
    end else begin
      walk_cnt <= walk_cnt + 1'b1;
    end
  end

  // Output stage: LED mux registered onto the pins
  always_ff @(posedge clk) begin
    if (reset) begin
      led_out <= '0;
    end else begin
      case (mode)
        LED_PASS: led_out <= led_in;
        LED_PWM:  led_out <= led_in & {NUM_LED{pwm_lit}};
        LED_HB:   led_out <= {led_in[NUM_LED-1:1], hb};
        LED_WALK: led_out <= walk_ptr;
        default:  led_out <= led_in;
      endcase
    end
  end

endmodule

// File: tb/tb_board_io_ctrl.sv
// tb_board_io_ctrl
//   Scoreboard bench for board_io_ctrl. The stimulus process evaluates a
//   reference model expressed in terms of elapsed cycles and input history
//   and queues the expected outputs for each clock edge; an independent
//   monitor compares them against the DUT on the falling edge.
module tb_board_io_ctrl;

  localparam int NUM_SW       = 4;
  localparam int NUM_LED      = 8;
  localparam int DEBOUNCE_CYC = 8;
  localparam int RST_STRETCH  = 4;
  localparam int PWM_BITS     = 4;
  localparam int HB_CYC       = 5;
  localparam int WALK_CYC     = 3;
  localparam int MAX_EDGES    = 8192;

  logic                clk = 1'b0;
  logic                reset;
  logic [NUM_SW-1:0]   sw_raw;
  logic [NUM_SW-1:0]   sw_db;
  logic [NUM_SW-1:0]   sw_rise;
  logic                cpu_reset;
  logic [NUM_LED-1:0]  led_in;
  logic [1:0]          led_mode;
  logic [PWM_BITS-1:0] pwm_duty;
  logic [NUM_LED-1:0]  led_out;

  board_io_ctrl #(
    .NUM_SW      (NUM_SW),
    .NUM_LED     (NUM_LED),
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .RST_STRETCH (RST_STRETCH),
    .PWM_BITS    (PWM_BITS),
    .HB_CYC      (HB_CYC),
    .WALK_CYC    (WALK_CYC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sw_raw   (sw_raw),
    .sw_db    (sw_db),
    .sw_rise  (sw_rise),
    .cpu_reset(cpu_reset),
    .led_in   (led_in),
    .led_mode (led_mode),
    .pwm_duty (pwm_duty),
    .led_out  (led_out)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                 cyc;
    logic [NUM_SW-1:0]  db;
    logic [NUM_SW-1:0]  rise;
    logic               cpu;
    logic [NUM_LED-1:0] led;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check_val(input string name, input int at, input logic [31:0] got,
                           input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, at, got, want);
    end
  endtask

  // Monitor: compares whatever expectation belongs to the edge just taken
  always @(negedge clk) begin
    if (q.size() != 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      check_val("edge_tag", cyc, 32'(mon_e.cyc), 32'(cyc));
      check_val("sw_db", cyc, 32'(sw_db), 32'(mon_e.db));
      check_val("sw_rise", cyc, 32'(sw_rise), 32'(mon_e.rise));
      check_val("cpu_reset", cyc, 32'(cpu_reset), 32'(mon_e.cpu));
      check_val("led_out", cyc, 32'(led_out), 32'(mon_e.led));
    end
  end

  // ---------------- reference model ----------------
  logic [NUM_SW-1:0] raw_log [MAX_EDGES];
  logic [NUM_SW-1:0] m_db      = '0;
  int                last_rst   = 0;
  int                last_cause = 0;
  int                walk_run   = 0;

  // Switch value the debouncer sees at edge e: raw delayed two edges,
  // zero while the synchroniser is still refilling after a reset.
  function automatic logic [NUM_SW-1:0] seen_sw(input int e);
    return (e - 2 > last_rst) ? raw_log[e-2] : '0;
  endfunction

  // Evaluate the next edge with the current inputs, queue the result, advance
  task automatic step();
    exp_t              e;
    int                k;
    logic [NUM_SW-1:0] db_pre;
    logic              all_diff;
    int                pwm_pos;
    logic              hb_v;
    k = cyc + 1;
    if (k >= MAX_EDGES) begin
      $display("FAIL edge_budget at edge %0d: got overflow, expected < %0d", k, MAX_EDGES);
      $fatal(1);
    end
    raw_log[k] = sw_raw;
    e.cyc  = k;
    e.rise = '0;
    if (reset) begin
      m_db       = '0;
      last_rst   = k;
      last_cause = k;
      walk_run   = 0;
      e.led      = '0;
    end else begin
      db_pre  = m_db;
      pwm_pos = (k - 1 - last_rst) % (1 << PWM_BITS);
      hb_v    = (((k - 1 - last_rst) / HB_CYC) % 2) == 1;
      case (led_mode)
        2'd0: e.led = led_in;
        2'd1: e.led = (pwm_pos < int'(pwm_duty)) ? led_in : '0;
        2'd2: e.led = {led_in[NUM_LED-1:1], hb_v};
        default: begin
          e.led = '0;
          e.led[(walk_run / WALK_CYC) % NUM_LED] = 1'b1;
        end
      endcase
      walk_run = (led_mode == 2'd3) ? walk_run + 1 : 0;
      // A level is accepted once the last DEBOUNCE_CYC seen values all differ
      for (int i = 0; i < NUM_SW; i++) begin
        if (k - DEBOUNCE_CYC + 1 > last_rst) begin
          all_diff = 1'b1;
          for (int j = 0; j < DEBOUNCE_CYC; j++)
            if (seen_sw(k - j)[i] == m_db[i]) all_diff = 1'b0;
          if (all_diff) begin
            m_db[i]   = ~m_db[i];
            e.rise[i] = m_db[i];
          end
        end
      end
      if (db_pre[0]) last_cause = k;
    end
    e.db  = m_db;
    e.cpu = m_db[0] | ((k - last_cause) < RST_STRETCH);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int idx;
    reset    = 1'b1;
    sw_raw   = '0;
    led_in   = '0;
    led_mode = 2'd0;
    pwm_duty = '0;

    // Reset and stretched CPU reset release
    run(3);
    reset = 1'b0;
    run(8);

    // Switch 1: clean press, release, then a one-cycle glitch
    sw_raw[1] = 1'b1;
    run(15);
    sw_raw[1] = 1'b0;
    run(15);
    sw_raw[1] = 1'b1;
    run(1);
    sw_raw[1] = 1'b0;
    run(14);

    // Switch 0: drives cpu_reset; then a reset pulse in the middle of the stretch
    sw_raw[0] = 1'b1;
    run(20);
    sw_raw[0] = 1'b0;
    run(16);
    sw_raw[0] = 1'b1;
    run(20);
    sw_raw[0] = 1'b0;
    run(12);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(10);

    // PWM dimming
    led_mode = 2'd1;
    led_in   = 8'hFF;
    pwm_duty = 4'd4;
    run(32);
    pwm_duty = 4'd15;
    run(16);
    pwm_duty = 4'd0;
    run(16);

    // Heartbeat
    led_mode = 2'd2;
    led_in   = 8'hA5;
    run(25);

    // Walking one, interrupted and restarted
    led_mode = 2'd3;
    run(30);
    led_mode = 2'd0;
    run(3);
    led_mode = 2'd3;
    run(10);

    // Randomised traffic
    for (int n = 0; n < 700; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        idx = $urandom_range(0, NUM_SW - 1);
        sw_raw[idx] = ~sw_raw[idx];
      end
      if ($urandom_range(0, 24) == 0) led_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)  led_in   = NUM_LED'($urandom);
      if ($urandom_range(0, 39) == 0) pwm_duty = PWM_BITS'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;
    run(12);

    // Let the monitor consume the last expectation
    repeat (2) @(posedge clk);
    check_val("drain", cyc, 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog at edge %0d: got no completion, expected finish", cyc);
    $fatal(1);
  end

endmodule
